// File: rtl/vx_index_retire_queue_pkg.sv
// Shared definitions for the index retire queue: width helpers, default
// geometry, pointer types and the pointer-difference function.
// Optional feature macro used by this slice: INDEX_QUEUE_FLUSH_EN.
package vx_index_retire_queue_pkg;

  // Ceiling log2 that never returns zero, so a 1-entry dimension still gets a bit.
  function automatic int log2up(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  localparam int IQ_SIZE  = 8;
  localparam int IQ_ADDRW = log2up(IQ_SIZE);
  localparam int IQ_PTRW  = IQ_ADDRW + 1;
  localparam int IQ_CNTW  = log2up(IQ_SIZE + 1);

  typedef logic [IQ_ADDRW-1:0] addr_t;
  typedef logic [IQ_PTRW-1:0]  ptr_t;

  // Occupancy from wrap-bit pointers: difference taken modulo 2^ptrw.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wr_ptr,
                                           input logic [31:0] rd_ptr,
                                           input int          ptrw);
    logic [31:0] mask;
    mask = (32'd1 << ptrw) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/vx_index_retire_queue_retire_scan.sv
// Combinational head scan: counts the run of allocated-and-released slots
// starting at the head, capped at RETIRE_W.
module vx_index_retire_queue_retire_scan
  import vx_index_retire_queue_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int RETIRE_W = 2,
  localparam int ADDRW   = log2up(SIZE),
  localparam int CNTW    = log2up(SIZE + 1),
  localparam int RCW     = log2up(RETIRE_W + 1)
) (
  input  logic [SIZE-1:0]  valid,
  input  logic [ADDRW-1:0] rd_a,
  input  logic [CNTW-1:0]  count,
  output logic [RCW-1:0]   retire_cnt
);

  // slot_done[i]: head+i is allocated and already released
  logic [RETIRE_W-1:0] slot_done;
  logic                run;

  generate
    for (genvar gi = 0; gi < RETIRE_W; gi++) begin : g_slot
      logic [ADDRW-1:0] idx;
      assign idx           = rd_a + ADDRW'(gi);
      assign slot_done[gi] = (count > CNTW'(gi)) && !valid[idx];
    end
  endgenerate

  // Length of the leading done-run; stops at the first slot still in flight.
  always_comb begin
    retire_cnt = '0;
    run        = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      run = run & slot_done[i];
      if (run) retire_cnt = retire_cnt + RCW'(1);
    end
  end

endmodule

// File: rtl/vx_index_retire_queue.sv
// In-order slot allocator with out-of-order release by index and
// multi-slot in-order retire at the head.
// Optional feature: define INDEX_QUEUE_FLUSH_EN to add a synchronous flush port.
module vx_index_retire_queue
  import vx_index_retire_queue_pkg::*;
#(
  parameter int DATAW    = 1,
  parameter int SIZE     = IQ_SIZE,
  parameter int NUM_RELS = 2,
  parameter int NUM_RDS  = 2,
  parameter int RETIRE_W = 2,
  localparam int ADDRW   = log2up(SIZE),
  localparam int PTRW    = ADDRW + 1,
  localparam int CNTW    = log2up(SIZE + 1),
  localparam int RCW     = log2up(RETIRE_W + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATAW-1:0]          write_data,
  output logic [ADDRW-1:0]          write_addr,
  output logic                      full,
  output logic                      empty,
  output logic [CNTW-1:0]           count,
  input  logic [NUM_RELS-1:0]       rel_valid,
  input  logic [NUM_RELS*ADDRW-1:0] rel_addr,
  input  logic [NUM_RDS*ADDRW-1:0]  rd_addr,
  output logic [NUM_RDS*DATAW-1:0]  rd_data,
`ifdef INDEX_QUEUE_FLUSH_EN
  input  logic                      flush,
`endif
  output logic [RCW-1:0]            retire_cnt
);

  logic [PTRW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTRW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [SIZE-1:0]  valid_reg, valid_next;
  logic [DATAW-1:0] entries [SIZE];

  logic [ADDRW-1:0] rd_a;
  logic [ADDRW-1:0] wr_a;
  logic             push_ok;
  logic [RCW-1:0]   scan_cnt;
  logic [SIZE-1:0]  rel_clr [NUM_RELS];

  assign rd_a = rd_ptr_reg[ADDRW-1:0];
  assign wr_a = wr_ptr_reg[ADDRW-1:0];

  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (wr_a == rd_a) && (wr_ptr_reg[ADDRW] != rd_ptr_reg[ADDRW]);
  assign count      = CNTW'(ptr_diff(32'(wr_ptr_reg), 32'(rd_ptr_reg), PTRW));
  assign write_addr = wr_a;

  // full is the registered state: a same-cycle retire never opens room for a push
`ifdef INDEX_QUEUE_FLUSH_EN
  assign push_ok = push && !full && !flush;
`else
  assign push_ok = push && !full;
`endif

  vx_index_retire_queue_retire_scan #(
    .SIZE       (SIZE),
    .RETIRE_W   (RETIRE_W)
  ) retire_scan (
    .valid      (valid_reg),
    .rd_a       (rd_a),
    .count      (count),
    .retire_cnt (scan_cnt)
  );

`ifdef INDEX_QUEUE_FLUSH_EN
  assign retire_cnt = flush ? '0 : scan_cnt;
`else
  assign retire_cnt = scan_cnt;
`endif

  // Per-port one-hot clear mask; duplicate indices simply OR together
  generate
    for (genvar gi = 0; gi < NUM_RELS; gi++) begin : g_rel
      logic [ADDRW-1:0] addr;
      assign addr        = rel_addr[gi*ADDRW +: ADDRW];
      assign rel_clr[gi] = rel_valid[gi] ? ({{(SIZE-1){1'b0}}, 1'b1} << addr) : '0;
    end
  endgenerate

  // Asynchronous read ports: show stored payload, no bypass of this cycle's push
  generate
    for (genvar gi = 0; gi < NUM_RDS; gi++) begin : g_rd
      assign rd_data[gi*DATAW +: DATAW] = entries[rd_addr[gi*ADDRW +: ADDRW]];
    end
  endgenerate

  // Next-state for pointers and valid vector: release, push, retire, then flush override
  always_comb begin
    valid_next  = valid_reg;
    rd_ptr_next = rd_ptr_reg + PTRW'(scan_cnt);
    wr_ptr_next = wr_ptr_reg;
    for (int p = 0; p < NUM_RELS; p++) begin
      valid_next = valid_next & ~rel_clr[p];
    end
    if (push_ok) begin
      valid_next[wr_a] = 1'b1;
      wr_ptr_next      = wr_ptr_reg + PTRW'(1);
    end
`ifdef INDEX_QUEUE_FLUSH_EN
    if (flush) begin
      valid_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end
`endif
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      valid_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      valid_reg  <= valid_next;
    end
  end

  // Payload storage: written on accepted push, never reset
  always_ff @(posedge clk) begin
    if (push_ok) entries[wr_a] <= write_data;
  end

  // Runtime check: push against a full queue is dropped
  always @(posedge clk) begin
    if (reset) begin
      assert (!(push && full))
        else $warning("iq: push while full ignored");
    end
  end

  // Runtime check: release must name a slot that is currently in flight
  generate
    for (genvar gi = 0; gi < NUM_RELS; gi++) begin : g_rel_chk
      always @(posedge clk) begin
        if (reset && rel_valid[gi]) begin
          assert (valid_reg[g_rel[gi].addr])
            else $warning("iq: release of slot %0d that is not in flight ignored", g_rel[gi].addr);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_vx_index_retire_queue.sv
// Directed bench for vx_index_retire_queue (SIZE=8, RETIRE_W=2, 2 release
// ports, 2 read ports). Flush steps run only with INDEX_QUEUE_FLUSH_EN.
module tb_vx_index_retire_queue;

  logic       clk;
  logic       reset;
  logic       push;
  logic [0:0] write_data;
  logic [2:0] write_addr;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic [1:0] rel_valid;
  logic [5:0] rel_addr;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic [1:0] retire_cnt;
`ifdef INDEX_QUEUE_FLUSH_EN
  logic       flush;
`endif

  int checks = 0;
  int errors = 0;

  vx_index_retire_queue #(
    .DATAW      (1),
    .SIZE       (8),
    .NUM_RELS   (2),
    .NUM_RDS    (2),
    .RETIRE_W   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .write_data (write_data),
    .write_addr (write_addr),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .rel_valid  (rel_valid),
    .rel_addr   (rel_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
`ifdef INDEX_QUEUE_FLUSH_EN
    .flush      (flush),
`endif
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    push       = 1'b0;
    write_data = 1'b0;
    rel_valid  = 2'b00;
    rel_addr   = 6'd0;
    rd_addr    = 6'd0;
`ifdef INDEX_QUEUE_FLUSH_EN
    flush      = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_retire", 32'(retire_cnt), 32'd0);
    check("rst_waddr", 32'(write_addr), 32'd0);
    $display("step reset: empty=%0d count=%0d", empty, count);
    reset = 1'b1;
    tick();

    // Fill: 8 pushes, slot indices 0..7, data = i[0]
    for (int i = 0; i < 8; i++) begin
      push       = 1'b1;
      write_data = 1'(i);
      check("fill_waddr", 32'(write_addr), 32'(i));
      tick();
      $display("push %0d: write_addr=%0d count=%0d", i, write_addr, count);
    end
    push = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_empty", 32'(empty), 32'd0);
    // 9th push against full is dropped
    push = 1'b1;
    write_data = 1'b1;
    tick();
    push = 1'b0;
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_waddr", 32'(write_addr), 32'd0);
    $display("push overflow: count=%0d full=%0d", count, full);
    // read port 0 -> slot 5 (data 1), port 1 -> slot 2 (data 0)
    rd_addr = {3'd2, 3'd5};
    #1;
    check("rd_data", 32'(rd_data), 32'd1);
    $display("read: rd_data=%b", rd_data);

    // Out-of-order release: 2, then 1, then 0
    rel_valid = 2'b01; rel_addr = {3'd0, 3'd2};
    tick();
    check("rel2_retire", 32'(retire_cnt), 32'd0);
    rel_addr = {3'd0, 3'd1};
    tick();
    check("rel1_retire", 32'(retire_cnt), 32'd0);
    check("rel1_count", 32'(count), 32'd8);
    rel_addr = {3'd0, 3'd0};
    tick();
    rel_valid = 2'b00;
    check("rel0_retire", 32'(retire_cnt), 32'd2);
    check("rel0_count", 32'(count), 32'd8);
    tick();
    check("ret2_count", 32'(count), 32'd6);
    check("ret2_retire", 32'(retire_cnt), 32'd1);
    tick();
    check("ret1_count", 32'(count), 32'd5);
    check("ret1_retire", 32'(retire_cnt), 32'd0);
    check("ret1_full", 32'(full), 32'd0);
    $display("release ooo: count=%0d", count);

    // Same slot 3 released on both ports
    rel_valid = 2'b11; rel_addr = {3'd3, 3'd3};
    tick();
    rel_valid = 2'b00;
    check("dbl_retire", 32'(retire_cnt), 32'd1);
    tick();
    check("dbl_count", 32'(count), 32'd4);
    $display("double release: count=%0d", count);
    // Release of an already-retired slot is ignored
    rel_valid = 2'b01; rel_addr = {3'd0, 3'd1};
    tick();
    rel_valid = 2'b00;
    check("bad_count", 32'(count), 32'd4);
    check("bad_retire", 32'(retire_cnt), 32'd0);
    check("bad_waddr", 32'(write_addr), 32'd0);
    $display("bogus release: count=%0d", count);

    // Concurrent push + release of head (slot 4); read slot 0 has old data 0
    push = 1'b1; write_data = 1'b1;
    rel_valid = 2'b01; rel_addr = {3'd0, 3'd4};
    rd_addr = {3'd0, 3'd0};
    #1;
    check("cc_waddr", 32'(write_addr), 32'd0);
    check("cc_rd_old", 32'(rd_data[0]), 32'd0);
    tick();
    push = 1'b0; rel_valid = 2'b00;
    check("cc_count1", 32'(count), 32'd5);
    check("cc_retire1", 32'(retire_cnt), 32'd1);
    check("cc_rd_new", 32'(rd_data[0]), 32'd1);
    tick();
    check("cc_count2", 32'(count), 32'd4);
    $display("concurrent: count=%0d", count);

    // Async reset mid-cycle with count=5
    push = 1'b1; write_data = 1'b0;
    tick();
    push = 1'b0;
    check("pre_rst_count", 32'(count), 32'd5);
    #3;
    reset = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_count", 32'(count), 32'd0);
    check("arst_waddr", 32'(write_addr), 32'd0);
    $display("async reset: empty=%0d count=%0d", empty, count);
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef INDEX_QUEUE_FLUSH_EN
    // Flush overrides push and pending retire
    push = 1'b1;
    tick();
    tick();
    push = 1'b0;
    rel_valid = 2'b01; rel_addr = {3'd0, 3'd0};
    tick();
    rel_valid = 2'b00;
    check("fl_pre_retire", 32'(retire_cnt), 32'd1);
    flush = 1'b1; push = 1'b1;
    #1;
    check("fl_retire", 32'(retire_cnt), 32'd0);
    tick();
    flush = 1'b0; push = 1'b0;
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_count", 32'(count), 32'd0);
    check("fl_waddr", 32'(write_addr), 32'd0);
    $display("flush: empty=%0d count=%0d", empty, count);
`endif

    // Wrap: 20 push/release/retire rounds
    for (int r = 0; r < 20; r++) begin
      check("wr_empty", 32'(empty), 32'd1);
      check("wr_waddr", 32'(write_addr), 32'(r % 8));
      push = 1'b1; write_data = 1'(r);
      tick();
      push = 1'b0;
      rel_valid = 2'b01;
      rel_addr = {3'd0, 3'(r % 8)};
      tick();
      rel_valid = 2'b00;
      check("wr_retire", 32'(retire_cnt), 32'd1);
      tick();
      $display("wrap round %0d: empty=%0d", r, empty);
    end
    check("wrap_end_empty", 32'(empty), 32'd1);
    check("wrap_end_count", 32'(count), 32'd0);
    check("wrap_end_waddr", 32'(write_addr), 32'd4);

    // Refill after wrap: full detection with toggled wrap bits
    push = 1'b1;
    repeat (8) tick();
    push = 1'b0;
    check("refill_full", 32'(full), 32'd1);
    check("refill_count", 32'(count), 32'd8);
    check("refill_waddr", 32'(write_addr), 32'd4);
    $display("refill: full=%0d count=%0d", full, count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
